// File: rtl/hart_sched_n.sv
// -----------------------------------------------------------------------------
// hart_sched_n
//
// Purpose:
//   Per-hart lifecycle tracker (IDLE / ACTIVE / WAIT_I / WAIT_D) plus a
//   registered round-robin issue arbiter that drives the IF-stage hart select.
//   SWITCH_MODE 0 rotates to the next active hart every cycle. SWITCH_MODE 1
//   keeps the current hart until a branch/load event, a quota expiry (MAX_RUN
//   cycles) or the hart leaving ACTIVE.
//
// Ports:
//   clk, rst                : clock, synchronous active-low reset
//   set_hart/_id/_val       : software request to activate (1) or idle (0) a hart
//   is_branch, is_load      : ID-stage instruction class, owner in id_hstate
//   i_cache_miss, if_hstate : IF miss and its one-hot owner
//   use_cache_miss, use_hstate : D-side miss at use and its one-hot owner
//   i_cache_fin(_hstate)    : I refill done and its one-hot owner
//   d_cache_fin(_hstate)    : D refill done and its one-hot owner
//   hart_issue_valid/hid/hstate : registered issuing hart (valid, binary, one-hot)
//   hart_acti/wait/idle_hstate  : per-hart state bit-vectors
// -----------------------------------------------------------------------------
module hart_sched_n #(
    parameter int HART_NUM    = 4,
    parameter int HART_ID_W   = 2,
    parameter int SWITCH_MODE = 0,
    parameter int MAX_RUN     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_hart,
    input  logic [HART_ID_W-1:0] set_hart_id,
    input  logic                 set_hart_val,
    input  logic                 is_branch,
    input  logic                 is_load,
    input  logic [HART_NUM-1:0]  id_hstate,
    input  logic                 i_cache_miss,
    input  logic [HART_NUM-1:0]  if_hstate,
    input  logic                 use_cache_miss,
    input  logic [HART_NUM-1:0]  use_hstate,
    input  logic                 i_cache_fin,
    input  logic [HART_NUM-1:0]  i_cache_fin_hstate,
    input  logic                 d_cache_fin,
    input  logic [HART_NUM-1:0]  d_cache_fin_hstate,
    output logic                 hart_issue_valid,
    output logic [HART_ID_W-1:0] hart_issue_hid,
    output logic [HART_NUM-1:0]  hart_issue_hstate,
    output logic [HART_NUM-1:0]  hart_acti_hstate,
    output logic [HART_NUM-1:0]  hart_wait_hstate,
    output logic [HART_NUM-1:0]  hart_idle_hstate
);

    typedef enum logic [1:0] {
        HS_IDLE   = 2'd0,
        HS_ACTIVE = 2'd1,
        HS_WAIT_I = 2'd2,
        HS_WAIT_D = 2'd3
    } hartState_t;

    hartState_t              r_state     [HART_NUM];
    hartState_t              w_stateNext [HART_NUM];
    logic [HART_NUM-1:0]     w_actNext;

    logic [HART_NUM-1:0]     r_issueHot;
    logic [HART_ID_W-1:0]    r_hid;
    logic                    r_valid;
    logic [7:0]              r_runCnt;

    logic                    w_rotFound;
    logic [HART_ID_W-1:0]    w_rotId;
    logic                    w_switchEvt;
    logic                    w_quotaOk;
    logic                    w_stay;

    // State register for every hart's lifecycle FSM. Reset leaves hart 0
    // running so the pipeline always has something to fetch after reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int h = 0; h < HART_NUM; h++) begin
                r_state[h] <= (h == 0) ? HS_ACTIVE : HS_IDLE;
            end
        end else begin
            for (int h = 0; h < HART_NUM; h++) begin
                r_state[h] <= w_stateNext[h];
            end
        end
    end

    // Next-state logic per hart. A software idle request wins over everything
    // and silently drops any outstanding refill, so a late fin finds the hart
    // IDLE and is ignored. A D-side miss outranks a simultaneous I refill,
    // which is why WAIT_I checks the use miss before its own fin.
    always_comb begin
        for (int h = 0; h < HART_NUM; h++) begin
            w_stateNext[h] = r_state[h];
            if (set_hart && (set_hart_id == HART_ID_W'(h)) && !set_hart_val) begin
                w_stateNext[h] = HS_IDLE;
            end else begin
                case (r_state[h])
                    HS_IDLE: begin
                        if (set_hart && (set_hart_id == HART_ID_W'(h))) begin
                            w_stateNext[h] = HS_ACTIVE;
                        end
                    end
                    HS_ACTIVE: begin
                        if (use_cache_miss && use_hstate[h]) begin
                            w_stateNext[h] = HS_WAIT_D;
                        end else if (i_cache_miss && if_hstate[h]) begin
                            w_stateNext[h] = HS_WAIT_I;
                        end
                    end
                    HS_WAIT_I: begin
                        if (use_cache_miss && use_hstate[h]) begin
                            w_stateNext[h] = HS_WAIT_D;
                        end else if (i_cache_fin && i_cache_fin_hstate[h]) begin
                            w_stateNext[h] = HS_ACTIVE;
                        end
                    end
                    HS_WAIT_D: begin
                        if (d_cache_fin && d_cache_fin_hstate[h]) begin
                            w_stateNext[h] = HS_ACTIVE;
                        end
                    end
                    default: w_stateNext[h] = HS_IDLE;
                endcase
            end
        end
    end

    // Output decode of the lifecycle FSMs into the three status bit-vectors.
    // These come straight from registered state so they are glitch-free.
    always_comb begin
        hart_acti_hstate = '0;
        hart_wait_hstate = '0;
        hart_idle_hstate = '0;
        for (int h = 0; h < HART_NUM; h++) begin
            hart_acti_hstate[h] = (r_state[h] == HS_ACTIVE);
            hart_wait_hstate[h] = (r_state[h] == HS_WAIT_I) || (r_state[h] == HS_WAIT_D);
            hart_idle_hstate[h] = (r_state[h] == HS_IDLE);
        end
    end

    // The arbiter looks at next-cycle ACTIVE harts so a hart that misses this
    // cycle is never picked for the following one.
    always_comb begin
        w_actNext = '0;
        for (int h = 0; h < HART_NUM; h++) begin
            w_actNext[h] = (w_stateNext[h] == HS_ACTIVE);
        end
    end

    // Round-robin search starting just after the current (or last held) hid
    // and wrapping back onto it. HART_NUM is a power of two, so the id adder
    // wraps on its own; k == HART_NUM lands back on r_hid itself.
    always_comb begin
        w_rotFound = 1'b0;
        w_rotId    = r_hid;
        for (int k = 1; k <= HART_NUM; k++) begin
            if (!w_rotFound && w_actNext[r_hid + HART_ID_W'(k)]) begin
                w_rotFound = 1'b1;
                w_rotId    = r_hid + HART_ID_W'(k);
            end
        end
    end

    // Coarse-mode stay decision: keep the current hart while it remains
    // active, no branch/load of its own is in ID, and the quota is not used up.
    always_comb begin
        w_switchEvt = (is_branch | is_load) && (id_hstate == r_issueHot);
        w_quotaOk   = ({1'b0, r_runCnt} + 9'd1) < 9'(MAX_RUN);
        w_stay      = (SWITCH_MODE != 0) && r_valid && w_actNext[r_hid]
                      && !w_switchEvt && w_quotaOk;
    end

    // Issue register. With no active hart the one-hot and valid drop but hid
    // is held so the next search resumes where rotation left off.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_issueHot <= HART_NUM'(1);
            r_hid      <= '0;
            r_valid    <= 1'b1;
            r_runCnt   <= '0;
        end else if (w_actNext == '0) begin
            r_issueHot <= '0;
            r_valid    <= 1'b0;
            r_runCnt   <= '0;
        end else if (w_stay) begin
            r_runCnt   <= r_runCnt + 8'd1;
        end else begin
            r_issueHot <= HART_NUM'(1) << w_rotId;
            r_hid      <= w_rotId;
            r_valid    <= 1'b1;
            r_runCnt   <= '0;
        end
    end

    assign hart_issue_valid  = r_valid;
    assign hart_issue_hid    = r_hid;
    assign hart_issue_hstate = r_issueHot;

endmodule

// File: tb/tb_hart_sched_n.sv
// -----------------------------------------------------------------------------
// tb_hart_sched_n
//
// Purpose:
//   Drives two instances of hart_sched_n from the same inputs: one in
//   fine-grained mode (default parameters) and one in coarse mode with
//   MAX_RUN = 4. A behavioural model holds each hart's state as a small
//   integer and the issuer as a plain hart index with a run count, and every
//   cycle all outputs of both instances are compared against it.
// -----------------------------------------------------------------------------
module tb_hart_sched_n;

    localparam int N = 4;

    logic       clk;
    logic       rst;
    logic       set_hart;
    logic [1:0] set_hart_id;
    logic       set_hart_val;
    logic       is_branch;
    logic       is_load;
    logic [3:0] id_hstate;
    logic       i_cache_miss;
    logic [3:0] if_hstate;
    logic       use_cache_miss;
    logic [3:0] use_hstate;
    logic       i_cache_fin;
    logic [3:0] i_cache_fin_hstate;
    logic       d_cache_fin;
    logic [3:0] d_cache_fin_hstate;

    logic       valid0, valid1;
    logic [1:0] hid0, hid1;
    logic [3:0] hot0, hot1, acti0, acti1, wait0, wait1, idle0, idle1;

    int checkCount = 0;
    int passCount  = 0;

    // Model: 0 = idle, 1 = active, 2 = waiting on I refill, 3 = waiting on D refill.
    int mState [N];
    int mHid   [2];
    int mValid [2];
    int mCnt   [2];
    int modeOf [2] = '{0, 1};
    int quotaOf[2] = '{16, 4};

    hart_sched_n #(.HART_NUM(4), .HART_ID_W(2), .SWITCH_MODE(0), .MAX_RUN(16)) dut0 (
        .clk(clk), .rst(rst),
        .set_hart(set_hart), .set_hart_id(set_hart_id), .set_hart_val(set_hart_val),
        .is_branch(is_branch), .is_load(is_load), .id_hstate(id_hstate),
        .i_cache_miss(i_cache_miss), .if_hstate(if_hstate),
        .use_cache_miss(use_cache_miss), .use_hstate(use_hstate),
        .i_cache_fin(i_cache_fin), .i_cache_fin_hstate(i_cache_fin_hstate),
        .d_cache_fin(d_cache_fin), .d_cache_fin_hstate(d_cache_fin_hstate),
        .hart_issue_valid(valid0), .hart_issue_hid(hid0), .hart_issue_hstate(hot0),
        .hart_acti_hstate(acti0), .hart_wait_hstate(wait0), .hart_idle_hstate(idle0)
    );

    hart_sched_n #(.HART_NUM(4), .HART_ID_W(2), .SWITCH_MODE(1), .MAX_RUN(4)) dut1 (
        .clk(clk), .rst(rst),
        .set_hart(set_hart), .set_hart_id(set_hart_id), .set_hart_val(set_hart_val),
        .is_branch(is_branch), .is_load(is_load), .id_hstate(id_hstate),
        .i_cache_miss(i_cache_miss), .if_hstate(if_hstate),
        .use_cache_miss(use_cache_miss), .use_hstate(use_hstate),
        .i_cache_fin(i_cache_fin), .i_cache_fin_hstate(i_cache_fin_hstate),
        .d_cache_fin(d_cache_fin), .d_cache_fin_hstate(d_cache_fin_hstate),
        .hart_issue_valid(valid1), .hart_issue_hid(hid1), .hart_issue_hstate(hot1),
        .hart_acti_hstate(acti1), .hart_wait_hstate(wait1), .hart_idle_hstate(idle1)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports any mismatch.
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checkCount++;
        if (observed == expected) passCount++;
        else $display("[TB] FAIL %s: observed %0h expected %0h at t=%0t", tag, observed, expected, $time);
    endtask

    // Lifecycle rules for one hart, highest priority first.
    function automatic int hartNext(int cur, int h);
        bit mine;
        mine = set_hart && (int'(set_hart_id) == h);
        if (mine && !set_hart_val) return 0;
        if (cur == 0) return mine ? 1 : 0;
        if (use_cache_miss && use_hstate[h] && (cur == 1 || cur == 2)) return 3;
        if (i_cache_miss && if_hstate[h] && cur == 1) return 2;
        if (cur == 2 && i_cache_fin && i_cache_fin_hstate[h]) return 1;
        if (cur == 3 && d_cache_fin && d_cache_fin_hstate[h]) return 1;
        return cur;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic modelStep();
        int nxt [N];
        int actCount;
        bit evt, stay, found;
        if (!rst) begin
            for (int h = 0; h < N; h++) mState[h] = (h == 0) ? 1 : 0;
            for (int i = 0; i < 2; i++) begin
                mHid[i] = 0; mValid[i] = 1; mCnt[i] = 0;
            end
            return;
        end
        actCount = 0;
        for (int h = 0; h < N; h++) begin
            nxt[h] = hartNext(mState[h], h);
            if (nxt[h] == 1) actCount++;
        end
        for (int i = 0; i < 2; i++) begin
            if (actCount == 0) begin
                mValid[i] = 0;
                mCnt[i]   = 0;
            end else begin
                evt  = (is_branch || is_load) && mValid[i] == 1 && int'(id_hstate) == (1 << mHid[i]);
                stay = modeOf[i] == 1 && mValid[i] == 1 && nxt[mHid[i]] == 1 && !evt
                       && (mCnt[i] + 1 < quotaOf[i]);
                if (stay) begin
                    mCnt[i]++;
                end else begin
                    found = 0;
                    for (int k = 1; k <= N; k++) begin
                        if (!found && nxt[(mHid[i] + k) % N] == 1) begin
                            found   = 1;
                            mHid[i] = (mHid[i] + k) % N;
                        end
                    end
                    mValid[i] = 1;
                    mCnt[i]   = 0;
                end
            end
        end
        for (int h = 0; h < N; h++) mState[h] = nxt[h];
    endtask

    // Compare every output of both instances with the model.
    task automatic checkAll();
        int acti, waitV, idle;
        acti = 0; waitV = 0; idle = 0;
        for (int h = 0; h < N; h++) begin
            if (mState[h] == 1) acti |= (1 << h);
            if (mState[h] >= 2) waitV |= (1 << h);
            if (mState[h] == 0) idle |= (1 << h);
        end
        checkOutput("m0.valid", int'(valid0), mValid[0]);
        checkOutput("m0.hid",   int'(hid0),   mHid[0]);
        checkOutput("m0.hot",   int'(hot0),   mValid[0] ? (1 << mHid[0]) : 0);
        checkOutput("m0.acti",  int'(acti0),  acti);
        checkOutput("m0.wait",  int'(wait0),  waitV);
        checkOutput("m0.idle",  int'(idle0),  idle);
        checkOutput("m1.valid", int'(valid1), mValid[1]);
        checkOutput("m1.hid",   int'(hid1),   mHid[1]);
        checkOutput("m1.hot",   int'(hot1),   mValid[1] ? (1 << mHid[1]) : 0);
        checkOutput("m1.acti",  int'(acti1),  acti);
        checkOutput("m1.wait",  int'(wait1),  waitV);
        checkOutput("m1.idle",  int'(idle1),  idle);
    endtask

    // One clock: model consumes current inputs, DUTs clock, outputs sampled 1 unit later.
    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        #1;
        checkAll();
    endtask

    task automatic clearInputs();
        rst = 1'b1;
        set_hart = 1'b0; set_hart_id = 2'd0; set_hart_val = 1'b0;
        is_branch = 1'b0; is_load = 1'b0; id_hstate = 4'd0;
        i_cache_miss = 1'b0; if_hstate = 4'd0;
        use_cache_miss = 1'b0; use_hstate = 4'd0;
        i_cache_fin = 1'b0; i_cache_fin_hstate = 4'd0;
        d_cache_fin = 1'b0; d_cache_fin_hstate = 4'd0;
    endtask

    task automatic setHartCycle(input int id, input bit val);
        clearInputs();
        set_hart = 1'b1; set_hart_id = 2'(id); set_hart_val = val;
        applyStimulus();
        clearInputs();
    endtask

    task automatic idleCycles(input int n);
        clearInputs();
        repeat (n) applyStimulus();
    endtask

    // Random one-hot mask over the four harts.
    function automatic logic [3:0] randHot();
        return 4'(1 << $urandom_range(0, 3));
    endfunction

    initial begin
        $display("[TB] starting hart_sched_n bench");
        clearInputs();
        #2;

        // Reset for two cycles, then a few idle cycles with only hart 0 running.
        rst = 1'b0;
        applyStimulus();
        applyStimulus();
        idleCycles(3);

        // Bring harts 1..3 up in consecutive cycles and let them rotate.
        for (int id = 1; id < N; id++) setHartCycle(id, 1'b1);
        idleCycles(8);

        // I miss on hart 2 takes it out of rotation until its refill lands.
        clearInputs(); i_cache_miss = 1'b1; if_hstate = 4'b0100; applyStimulus();
        idleCycles(5);
        clearInputs(); i_cache_fin = 1'b1; i_cache_fin_hstate = 4'b0100; applyStimulus();
        idleCycles(5);

        // Only harts 0 and 1 active: coarse instance runs each for its quota.
        setHartCycle(2, 1'b0);
        setHartCycle(3, 1'b0);
        idleCycles(12);

        // Load from the coarse-mode issuer forces an early switch.
        clearInputs(); is_load = 1'b1; id_hstate = 4'(1 << mHid[1]); applyStimulus();
        idleCycles(3);
        clearInputs(); is_branch = 1'b1; id_hstate = 4'(1 << mHid[1]); applyStimulus();
        idleCycles(2);

        // Single active hart goes to WAIT_D: nothing issues until its refill.
        setHartCycle(1, 1'b0);
        idleCycles(1);
        clearInputs(); use_cache_miss = 1'b1; use_hstate = 4'b0001; applyStimulus();
        idleCycles(2);
        clearInputs(); d_cache_fin = 1'b1; d_cache_fin_hstate = 4'b0001; applyStimulus();
        idleCycles(2);

        // Idle request in the same cycle as the refill: the hart ends IDLE,
        // and a later stray fin is ignored.
        clearInputs(); i_cache_miss = 1'b1; if_hstate = 4'b0001; applyStimulus();
        clearInputs();
        set_hart = 1'b1; set_hart_id = 2'd0; set_hart_val = 1'b0;
        i_cache_fin = 1'b1; i_cache_fin_hstate = 4'b0001;
        applyStimulus();
        idleCycles(2);
        clearInputs(); i_cache_fin = 1'b1; i_cache_fin_hstate = 4'b0001; applyStimulus();
        setHartCycle(2, 1'b1);
        setHartCycle(3, 1'b1);
        idleCycles(3);

        // WAIT_I hart sees its fin and a use miss together: lands in WAIT_D.
        clearInputs(); i_cache_miss = 1'b1; if_hstate = 4'b1000; applyStimulus();
        clearInputs();
        i_cache_fin = 1'b1; i_cache_fin_hstate = 4'b1000;
        use_cache_miss = 1'b1; use_hstate = 4'b1000;
        applyStimulus();
        idleCycles(2);

        // Reset asserted together with pending events: reset wins.
        clearInputs();
        rst = 1'b0; set_hart = 1'b1; set_hart_id = 2'd3; set_hart_val = 1'b1;
        d_cache_fin = 1'b1; d_cache_fin_hstate = 4'b1000;
        applyStimulus();
        idleCycles(2);

        // Randomised traffic with occasional resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            clearInputs();
            rst            = ($urandom_range(0, 499) != 0);
            set_hart       = ($urandom_range(0, 3) == 0);
            set_hart_id    = 2'($urandom_range(0, 3));
            set_hart_val   = ($urandom_range(0, 3) != 0);
            is_branch      = ($urandom_range(0, 5) == 0);
            is_load        = ($urandom_range(0, 5) == 0);
            id_hstate      = ($urandom_range(0, 1) == 0) ? 4'(1 << mHid[1]) : randHot();
            i_cache_miss   = ($urandom_range(0, 7) == 0);
            if_hstate      = randHot();
            use_cache_miss = ($urandom_range(0, 7) == 0);
            use_hstate     = randHot();
            i_cache_fin    = ($urandom_range(0, 2) == 0);
            i_cache_fin_hstate = randHot();
            d_cache_fin    = ($urandom_range(0, 2) == 0);
            d_cache_fin_hstate = randHot();
            applyStimulus();
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
